// File: rtl/apb_slave_ram_pkg.sv
// Purpose : shared types and default widths for the APB slave RAM block.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package apb_slave_ram_pkg;

    // Default bus widths used as parameter defaults throughout the block.
    localparam int APB_DATA_WIDTH  = 32;
    localparam int APB_ADDR_WIDTH  = 32;
    localparam int MEM_DEPTH_DEF   = 1024;
    localparam int WAIT_CFG_WIDTH  = 4;
    localparam int SECURE_BASE_DEF = 768;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } slave_state_e;

endpackage

// File: rtl/apb_slave_ram_if.sv
// Purpose : APB4 completer-side bus bundle plus the per-transfer wait-state count.
// Latency : n/a (wires only).
// Backpressure: completer stalls the requester through PREADY.
// Ports   : master drives PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT/wait_cfg,
//           slave drives PRDATA/PREADY/PSLVERR.
interface apb_slave_ram_if
    import apb_slave_ram_pkg::*;
#(
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH
);
    logic                        PSEL;
    logic                        PENABLE;
    logic                        PWRITE;
    logic [ADDR_WIDTH-1:0]       PADDR;
    logic [DATA_WIDTH-1:0]       PWDATA;
    logic [DATA_WIDTH/8-1:0]     PSTRB;
    logic [2:0]                  PPROT;
    logic [WAIT_CFG_WIDTH-1:0]   wait_cfg;
    logic [DATA_WIDTH-1:0]       PRDATA;
    logic                        PREADY;
    logic                        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, wait_cfg,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, wait_cfg,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_ram_array.sv
// Purpose : word-addressed storage, synchronous byte-enable write, combinational read.
// Latency : write lands on the clock edge; read is same-cycle combinational.
// Backpressure: none, always accepts.
// Ports   : i_clk, i_we/i_waddr/i_wdata/i_wstrb write port, i_raddr/o_rdata read port.
module apb_ram_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                    i_clk,
    input  logic                    i_we,
    input  logic [IDX_W-1:0]        i_waddr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic [IDX_W-1:0]        i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata
);
    // Contents are intentionally not reset.
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (i_we && i_wstrb[i]) begin
                r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/apb_slave_ram.sv
// Purpose : APB4 completer backed by a byte-strobed RAM with programmable wait states.
// Latency : PREADY in access cycle T1+N for wait_cfg=N; write commits at end of PREADY cycle.
// Backpressure: holds PREADY low for N access cycles; PSEL drop during waits aborts.
// Ports   : PCLK, PRESET (async active-high), bus (apb_slave_ram_if.slave).
module apb_slave_ram
    import apb_slave_ram_pkg::*;
#(
    parameter int DATA_WIDTH  = APB_DATA_WIDTH,
    parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter int SECURE_BASE = SECURE_BASE_DEF
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb_slave_ram_if.slave bus
);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = DATA_WIDTH/8;

    slave_state_e               r_state;
    logic [WAIT_CFG_WIDTH-1:0]  r_cnt;
    logic                       r_write;
    logic                       r_err;
    logic [IDX_W-1:0]           r_addr;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic [STRB_W-1:0]          r_strb;
    logic [DATA_WIDTH-1:0]      r_prdata;
    logic                       r_pready;
    logic                       r_pslverr;

    logic                       w_setup;
    logic                       w_err;
    logic                       w_wr_en;
    logic [IDX_W-1:0]           w_rd_idx;
    logic [DATA_WIDTH-1:0]      w_mem_rdata;
    logic [DATA_WIDTH-1:0]      w_rd_data;
    logic                       w_unused_prot;

    assign w_setup = bus.PSEL && !bus.PENABLE &&
                     ((r_state == S_IDLE) || (r_state == S_DONE));

    assign w_err = (!bus.PWRITE && (bus.PSTRB != '0)) ||
                   (bus.PADDR >= ADDR_WIDTH'(MEM_DEPTH)) ||
                   (bus.PPROT[1] && (bus.PADDR >= ADDR_WIDTH'(SECURE_BASE)));

    // Only the non-secure bit matters here.
    assign w_unused_prot = bus.PPROT[0] ^ bus.PPROT[2];

    // The write retires on the edge that leaves S_DONE; gating with reset drops it.
    assign w_wr_en = (r_state == S_DONE) && r_write && !r_err && !PRESET;

    // A zero-wait read samples memory on its setup edge, so it must look at the
    // live address rather than the captured one.
    assign w_rd_idx = w_setup ? bus.PADDR[IDX_W-1:0] : r_addr;

    apb_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .i_clk   (PCLK),
        .i_we    (w_wr_en),
        .i_waddr (r_addr),
        .i_wdata (r_wdata),
        .i_wstrb (r_strb),
        .i_raddr (w_rd_idx),
        .o_rdata (w_mem_rdata)
    );

    // Back-to-back forwarding: a write retiring this edge is merged into a read
    // of the same word that samples memory on the same edge.
    always_comb begin
        w_rd_data = w_mem_rdata;
        if (w_wr_en && (r_addr == w_rd_idx)) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (r_strb[i]) begin
                    w_rd_data[8*i +: 8] = r_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_setup) begin
                        r_write <= bus.PWRITE;
                        r_addr  <= bus.PADDR[IDX_W-1:0];
                        r_wdata <= bus.PWDATA;
                        r_strb  <= bus.PSTRB;
                        r_err   <= w_err;
                        r_cnt   <= bus.wait_cfg;
                        if (bus.wait_cfg == '0) begin
                            r_state   <= S_DONE;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            if (!bus.PWRITE && !w_err) begin
                                r_prdata <= w_rd_data;
                            end
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!bus.PSEL) begin
                        r_state <= S_IDLE;
                    end else if (bus.PENABLE) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == WAIT_CFG_WIDTH'(1)) begin
                            r_state   <= S_DONE;
                            r_pready  <= 1'b1;
                            r_pslverr <= r_err;
                            if (!r_write && !r_err) begin
                                r_prdata <= w_rd_data;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.PRDATA  = r_prdata;
    assign bus.PREADY  = r_pready;
    assign bus.PSLVERR = r_pslverr;
endmodule

// File: tb/tb_apb_slave_ram.sv
// Purpose : self-checking bench for apb_slave_ram using a response scoreboard.
// Latency : checks PREADY arrives exactly wait_cfg access cycles after T1.
// Backpressure: driver waits on PREADY with a bounded cycle budget.
module tb_apb_slave_ram;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    apb_slave_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    apb_slave_ram #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .MEM_DEPTH   (1024),
        .SECURE_BASE (768)
    ) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus.slave)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [0:1023];
    logic [31:0] prdata_mdl = '0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Response side of the scoreboard: every PREADY pops one expectation.
    always @(negedge clk) begin
        if (bus.PREADY === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("prdata", bus.PRDATA, e.rdata);
                chk("pslverr", {31'd0, bus.PSLVERR}, {31'd0, e.err});
            end
        end
    end

    task automatic idle_bus();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0;  bus.PWDATA = '0;    bus.PSTRB = '0;
        bus.PPROT = '0;  bus.wait_cfg = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 with the bus released.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot, input int n);
        logic err;
        exp_t e;
        int   cyc;
        err = (!wr && strb != 4'd0) || (addr >= 32'd1024) || (prot[1] && addr >= 32'd768);
        if (wr && !err) begin
            for (int i = 0; i < 4; i++) if (strb[i]) mdl[addr][8*i +: 8] = data[8*i +: 8];
        end
        if (!wr && !err) prdata_mdl = mdl[addr];
        e.rdata = prdata_mdl;
        e.err   = err;
        sb.push_back(e);

        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr;
        bus.PWDATA = data; bus.PSTRB = strb; bus.PPROT = prot; bus.wait_cfg = 4'(n);
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        bus.wait_cfg = 4'($urandom_range(15, 0));  // must be ignored outside setup
        cyc = 0;
        forever begin
            @(negedge clk);
            if (bus.PREADY === 1'b1) break;
            cyc++;
            if (cyc > 40) break;
        end
        chk("latency", 32'(cyc), 32'(n));
        @(posedge clk); #1;
        idle_bus();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        #3;
        chk("rst_pready", {31'd0, bus.PREADY}, 32'd0);
        chk("rst_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
        chk("rst_prdata", bus.PRDATA, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-word write/read, zero wait.
        xfer(1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 3'b000, 0);
        xfer(1'b0, 32'd5, 32'h0, 4'h0, 3'b000, 0);

        // Byte-lane merge, then a PSTRB=0 write that must change nothing.
        xfer(1'b1, 32'd9, 32'h11223344, 4'hF, 3'b000, 0);
        xfer(1'b1, 32'd9, 32'hAABBCCDD, 4'b0101, 3'b000, 1);
        xfer(1'b0, 32'd9, 32'h0, 4'h0, 3'b000, 0);
        xfer(1'b1, 32'd9, 32'hFFFFFFFF, 4'h0, 3'b000, 0);
        xfer(1'b0, 32'd9, 32'h0, 4'h0, 3'b000, 2);

        // Wait states then reload to zero.
        xfer(1'b0, 32'd5, 32'h0, 4'h0, 3'b000, 3);
        xfer(1'b0, 32'd9, 32'h0, 4'h0, 3'b000, 0);
        xfer(1'b0, 32'd5, 32'h0, 4'h0, 3'b000, 15);

        // Error cases leave memory and PRDATA alone.
        xfer(1'b1, 32'd0, 32'h0BADF00D, 4'hF, 3'b000, 0);
        xfer(1'b1, 32'd800, 32'h5EC00001, 4'hF, 3'b000, 0);
        xfer(1'b1, 32'd700, 32'h00C0FFEE, 4'hF, 3'b010, 0);
        xfer(1'b0, 32'd9, 32'h0, 4'h0, 3'b000, 0);
        xfer(1'b0, 32'd5, 32'h0, 4'h1, 3'b000, 0);
        xfer(1'b1, 32'd1024, 32'h12345678, 4'hF, 3'b000, 2);
        xfer(1'b1, 32'd800, 32'h87654321, 4'hF, 3'b010, 1);
        xfer(1'b0, 32'd800, 32'h0, 4'h0, 3'b010, 0);
        xfer(1'b0, 32'd0, 32'h0, 4'h0, 3'b000, 0);
        xfer(1'b0, 32'd800, 32'h0, 4'h0, 3'b000, 0);
        xfer(1'b0, 32'd700, 32'h0, 4'h0, 3'b010, 1);

        // Abort: PSEL dropped at T2 during a 5-wait write.
        begin
            int hits;
            hits = 0;
            bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'd5;
            bus.PWDATA = 32'hCAFEF00D; bus.PSTRB = 4'hF; bus.PPROT = 3'b000; bus.wait_cfg = 4'd5;
            @(posedge clk); #1;
            bus.PENABLE = 1'b1;
            @(negedge clk); if (bus.PREADY) hits++;
            @(posedge clk); #1;
            idle_bus();
            for (int i = 0; i < 8; i++) begin
                @(negedge clk); if (bus.PREADY) hits++;
            end
            chk("abort_pready", 32'(hits), 32'd0);
            @(posedge clk); #1;
        end
        xfer(1'b0, 32'd5, 32'h0, 4'h0, 3'b000, 0);

        // Back-to-back write then read of the same word.
        xfer(1'b1, 32'd20, 32'h12345678, 4'hF, 3'b000, 0);
        xfer(1'b0, 32'd20, 32'h0, 4'h0, 3'b000, 0);
        xfer(1'b1, 32'd20, 32'h00AB0000, 4'b0100, 3'b000, 0);
        xfer(1'b0, 32'd20, 32'h0, 4'h0, 3'b000, 0);

        // Short random soak over a small preloaded window.
        for (int a = 32; a < 48; a++) xfer(1'b1, 32'(a), $urandom, 4'hF, 3'b000, $urandom_range(2, 0));
        for (int k = 0; k < 40; k++) begin
            logic wr;
            wr = 1'($urandom_range(1, 0));
            xfer(wr, 32'($urandom_range(47, 32)), $urandom,
                 wr ? 4'($urandom_range(15, 0)) : 4'h0, 3'b000, $urandom_range(3, 0));
        end

        // Reset asserted between edges while waiting.
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 32'd9;
        bus.PSTRB = 4'h0; bus.PPROT = 3'b000; bus.wait_cfg = 4'd5;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_pready", {31'd0, bus.PREADY}, 32'd0);
        chk("mid_rst_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
        chk("mid_rst_prdata", bus.PRDATA, 32'd0);
        idle_bus();
        prdata_mdl = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 32'd20, 32'h0, 4'h0, 3'b000, 0);
        xfer(1'b0, 32'd5, 32'h0, 4'h0, 3'b000, 1);

        @(posedge clk); @(posedge clk); #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/apb_slave_ram.md
# apb_slave_ram

Downstream APB4 completer for the APB master stage. It receives PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT and returns PRDATA/PREADY/PSLVERR. It backs a word-addressed RAM with byte-lane write strobes and a per-transfer programmable wait-state count. Errors are flagged for illegal reads, out-of-range addresses and non-secure accesses to the protected region.

## Interface
- `DATA_WIDTH`, 32: PWDATA/PRDATA width; strobe width is DATA_WIDTH/8.
- `ADDR_WIDTH`, 32: PADDR width.
- `MEM_DEPTH`, 1024: number of words; PADDR is a word index.
- `SECURE_BASE`, 768: first word index of the secure region.
- `PCLK`  in  1: clock; all state changes on its rising edge.
- `PRESET`  in  1: asynchronous, active-high reset.
- `PSEL`  in  1: slave select.
- `PENABLE`  in  1: access phase.
- `PWRITE`  in  1: 1 = write, 0 = read.
- `PADDR`  in  ADDR_WIDTH: word index.
- `PWDATA`  in  DATA_WIDTH: write data.
- `PSTRB`  in  DATA_WIDTH/8: byte-lane write enables; must be 0 on reads.
- `PPROT`  in  3: protection; PPROT[1]=1 means non-secure.
- `wait_cfg`  in  4: wait-state count, sampled in the setup cycle.
- `PRDATA`  out  DATA_WIDTH: read data, registered.
- `PREADY`  out  1: transfer completion, registered.
- `PSLVERR`  out  1: error response, registered; meaningful only while PREADY=1.

## Operation
- **FSM states:** S_IDLE, S_WAIT, S_DONE.
- **Setup detect:** PSEL=1 and PENABLE=0 while in S_IDLE or S_DONE. On that edge the block captures PWRITE, PADDR, PWDATA, PSTRB, the error flag and `cnt <= wait_cfg`.
  - wait_cfg=0: go directly to S_DONE.
  - Otherwise: go to S_WAIT.
- **S_WAIT:** while PSEL=1 and PENABLE=1, `cnt` decrements each edge. When `cnt==1`, the next state is S_DONE. If PSEL=0, go to S_IDLE: transfer aborted, no memory write, PRDATA unchanged.
- **S_DONE:** lasts one cycle with PREADY=1. The next state is S_IDLE, or a new setup capture if PSEL=1 and PENABLE=0.
- **Error flag:** asserted if any of the following holds:
  - a read with PSTRB≠0;
  - PADDR ≥ MEM_DEPTH;
  - PPROT[1]=1 and PADDR ≥ SECURE_BASE.
- **Write:** on the S_DONE edge, if no error, each byte lane i with PSTRB[i]=1 gets PWDATA[8i+7:8i]. Other lanes keep their value. No sign extension. PSTRB=0 on a write is legal and is a no-op.
- **Read:** on the edge entering S_DONE, `PRDATA <= mem[PADDR]` if no error. On error PRDATA holds its previous value. PRDATA is held between reads.
- **PSLVERR:** loaded with the error flag on entry to S_DONE, and cleared on exit.
- **Reset:** PREADY=0, PSLVERR=0, PRDATA=0, state S_IDLE, cnt=0. Memory contents are not reset. A reset mid-transfer drops the transfer with no write.

## Timing
- Let T0 be the setup cycle and T1 the first access cycle.
- PREADY=1 in cycle T1+N for wait_cfg=N, i.e. exactly N wait cycles.
- PRDATA and PSLVERR are valid in the PREADY cycle.
- A write commits at the end of the PREADY cycle.
- Back-to-back transfers are supported: the cycle after PREADY may be the next setup. A read of an address written by the immediately preceding transfer returns the new data.
- PREADY is never asserted outside S_DONE.
- wait_cfg changes outside setup cycles have no effect.

## Structure
- **shared_pkg additions:**
  - `slave_state_e` enum {S_IDLE, S_WAIT, S_DONE};
  - `WAIT_CFG_WIDTH`=4;
  - `SECURE_BASE_DEF`=768.
- **Width macros:** reuse the APB width macros from `apb_defines.svh` as parameter defaults.
- **Sub-module `apb_ram_array`:** MEM_DEPTH×DATA_WIDTH storage with a synchronous byte-enable write port and a combinational read port. The FSM, counter and error logic stay in `apb_slave_ram`.

## Test plan
- **Full-word write/read, zero wait:** write 0xDEADBEEF to addr 5 with PSTRB=4'hF and wait_cfg=0, then read addr 5 → PREADY in T1 for both; PRDATA=0xDEADBEEF; PSLVERR=0.
- **Byte-lane merge:** preload addr 9 with 0x11223344, then write 0xAABBCCDD with PSTRB=4'b0101 → read returns 0x11BB33DD.
- **Wait states:** wait_cfg=3 on a read → PREADY low in T1–T3 and high in T4; cnt reload on the next setup with wait_cfg=0 → PREADY in T1.
- **Errors:** each of the following gives PSLVERR=1 in the PREADY cycle with memory and PRDATA unchanged:
  - read with PSTRB=4'h1;
  - write to addr 1024;
  - PPROT=3'b010 write to addr 800.
- **Abort:** drop PSEL at T2 with wait_cfg=5 → FSM returns to S_IDLE, no write, PREADY never asserted.
- **Reset mid-wait:** assert PRESET asynchronously between edges during S_WAIT → PREADY, PSLVERR and PRDATA go to 0 immediately; previously written memory data is still readable after release.
